// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM state codes,
// opcodes, ALU operation classes, datapath mux selects and the control word.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU control decoder classes; 2'b11 is left undefined.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       iord;
    logic       alusrca;
    logic       pcen;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// State-to-control-word decode for the multicycle controller. Moore outputs,
// qualified only by the memory handshake, the ALU zero flag and opcode legality.
module mc_outdec
  import mips_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   zero_i,
  input  logic   op_legal_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    // NOTE: every field gets a default before the case so no latch is inferred.
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.pcsrc   = PCSRC_ALU;
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcen    = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alusrcb    = SRCB_BRANCH;
        ctrl_o.aluop      = ALUOP_ADD;
        ctrl_o.illegal_op = ~op_legal_i;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.memtoreg   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord       = 1'b1;
        ctrl_o.memwrite   = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_RTYPEEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_REG;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.regdst     = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BEQEX: begin
        ctrl_o.alusrca    = 1'b1;
        ctrl_o.alusrcb    = SRCB_REG;
        ctrl_o.aluop      = ALUOP_SUB;
        ctrl_o.pcsrc      = PCSRC_ALUOUT;
        ctrl_o.pcen       = zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      S_JEX: begin
        ctrl_o.pcsrc      = PCSRC_JUMP;
        ctrl_o.pcen       = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: opcode decode, state register and next-state
// logic, with write enables suppressed in any cycle that reset is high.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int OP_WIDTH = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_WIDTH-1:0] op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                irwrite,
  output logic                memwrite,
  output logic                regwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                iord,
  output logic                alusrca,
  output logic                pcen,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [1:0]          aluop,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [3:0]          state_dbg
);

  localparam logic [OP_WIDTH-1:0] LW_OP    = OP_WIDTH'(OP_LW);
  localparam logic [OP_WIDTH-1:0] SW_OP    = OP_WIDTH'(OP_SW);
  localparam logic [OP_WIDTH-1:0] RTYPE_OP = OP_WIDTH'(OP_RTYPE);
  localparam logic [OP_WIDTH-1:0] BEQ_OP   = OP_WIDTH'(OP_BEQ);
  localparam logic [OP_WIDTH-1:0] ADDI_OP  = OP_WIDTH'(OP_ADDI);
  localparam logic [OP_WIDTH-1:0] J_OP     = OP_WIDTH'(OP_J);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   is_lw, is_sw, is_rtype, is_beq, is_addi, is_j, op_legal;

  assign is_lw    = (op == LW_OP);
  assign is_sw    = (op == SW_OP);
  assign is_rtype = (op == RTYPE_OP);
  assign is_beq   = (op == BEQ_OP);
  assign is_addi  = (op == ADDI_OP);
  assign is_j     = (op == J_OP);
  assign op_legal = is_lw | is_sw | is_rtype | is_beq | is_addi | is_j;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_rtype)  state_d = S_RTYPEEX;
        else if (is_beq)    state_d = S_BEQEX;
        else if (is_addi)   state_d = S_ADDIEX;
        else if (is_j)      state_d = S_JEX;
        else                state_d = S_FETCH;
      end
      S_MEMADR:  state_d = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      // Final states and the unused codes 12-15 all return to FETCH.
      default:   state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment; comb logic uses blocking.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  mc_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .op_legal_i  (op_legal),
    .ctrl_o      (ctrl)
  );

  // Enables are masked by reset combinationally so an aborted instruction
  // cannot commit anything in the reset cycle itself.
  assign irwrite    = ctrl.irwrite    & ~reset;
  assign memwrite   = ctrl.memwrite   & ~reset;
  assign regwrite   = ctrl.regwrite   & ~reset;
  assign pcen       = ctrl.pcen       & ~reset;
  assign instr_done = ctrl.instr_done & ~reset;
  assign illegal_op = ctrl.illegal_op & ~reset;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign iord       = ctrl.iord;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign aluop      = ctrl.aluop;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state code and full control
// word compared against hand-derived expectations.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       irwrite, memwrite, regwrite, regdst, memtoreg, iord, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       instr_done, illegal_op;
  logic [3:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control #(.OP_WIDTH(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .iord       (iord),
    .alusrca    (alusrca),
    .pcen       (pcen),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .aluop      (aluop),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  // Word layout: irwrite memwrite regwrite regdst memtoreg iord alusrca pcen
  //              alusrcb[2] pcsrc[2] aluop[2] instr_done illegal_op
  function automatic logic [15:0] w(input logic irw, mw, rw, rd, mtr, io, asa, pce,
                                    input logic [1:0] asb, pcs, aop,
                                    input logic dn, il);
    return {irw, mw, rw, rd, mtr, io, asa, pce, asb, pcs, aop, dn, il};
  endfunction

  logic [15:0] obs_w;
  assign obs_w = {irwrite, memwrite, regwrite, regdst, memtoreg, iord, alusrca, pcen,
                  alusrcb, pcsrc, aluop, instr_done, illegal_op};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check, then wait a cycle.
  task automatic step(input string tag, input logic rst, input logic mr, input logic [5:0] o,
                      input logic z, input logic [3:0] exp_st, input logic [15:0] exp_w);
    reset = rst; mem_ready = mr; op = o; zero = z;
    #1;
    check({tag, "_state"}, {12'd0, state_dbg}, {12'd0, exp_st});
    check({tag, "_ctrl"}, obs_w, exp_w);
    @(negedge clk);
  endtask

  logic [15:0] W_RST, W_FETCH, W_FWAIT, W_DEC, W_DECILL, W_ADR, W_MEMRD, W_MEMWB;
  logic [15:0] W_MEMWR, W_MEMWR_DN, W_RTEX, W_RTEX_RST, W_RTWB, W_ADDIWB;
  logic [15:0] W_BEQ1, W_BEQ0, W_JEX;

  initial begin
    W_RST      = w(0,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    W_FETCH    = w(1,0,0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 0,0);
    W_FWAIT    = w(0,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    W_DEC      = w(0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0);
    W_DECILL   = w(0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,1);
    W_ADR      = w(0,0,0,0,0,0,1,0, 2'b10, 2'b00, 2'b00, 0,0);
    W_MEMRD    = w(0,0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    W_MEMWB    = w(0,0,1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 1,0);
    W_MEMWR    = w(0,1,0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    W_MEMWR_DN = w(0,1,0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 1,0);
    W_RTEX     = w(0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b10, 0,0);
    W_RTEX_RST = W_RTEX;
    W_RTWB     = w(0,0,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0);
    W_ADDIWB   = w(0,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0);
    W_BEQ1     = w(0,0,0,0,0,0,1,1, 2'b00, 2'b01, 2'b01, 1,0);
    W_BEQ0     = w(0,0,0,0,0,0,1,0, 2'b00, 2'b01, 2'b01, 1,0);
    W_JEX      = w(0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 1,0);

    @(negedge clk);
    // Reset dominates mem_ready: no fetch enables while reset is high.
    step("reset",      1, 1, LW,  1, 4'd0,  W_RST);

    // lw, with one stalled fetch cycle first.
    step("lw_fwait",   0, 0, LW,  0, 4'd0,  W_FWAIT);
    step("lw_fetch",   0, 1, LW,  0, 4'd0,  W_FETCH);
    step("lw_decode",  0, 1, LW,  0, 4'd1,  W_DEC);
    step("lw_memadr",  0, 1, LW,  0, 4'd2,  W_ADR);
    step("lw_memrd",   0, 1, LW,  0, 4'd3,  W_MEMRD);
    step("lw_memwb",   0, 1, LW,  0, 4'd4,  W_MEMWB);

    // beq taken then not taken.
    step("beq1_fetch", 0, 1, BEQ, 1, 4'd0,  W_FETCH);
    step("beq1_dec",   0, 1, BEQ, 1, 4'd1,  W_DEC);
    step("beq1_ex",    0, 1, BEQ, 1, 4'd8,  W_BEQ1);
    step("beq0_fetch", 0, 1, BEQ, 0, 4'd0,  W_FETCH);
    step("beq0_dec",   0, 1, BEQ, 0, 4'd1,  W_DEC);
    step("beq0_ex",    0, 1, BEQ, 0, 4'd8,  W_BEQ0);

    // sw with three wait cycles in MEMWR.
    step("sw_fetch",   0, 1, SW,  0, 4'd0,  W_FETCH);
    step("sw_dec",     0, 1, SW,  0, 4'd1,  W_DEC);
    step("sw_memadr",  0, 1, SW,  0, 4'd2,  W_ADR);
    step("sw_wait1",   0, 0, SW,  0, 4'd5,  W_MEMWR);
    step("sw_wait2",   0, 0, SW,  0, 4'd5,  W_MEMWR);
    step("sw_wait3",   0, 0, SW,  0, 4'd5,  W_MEMWR);
    step("sw_done",    0, 1, SW,  0, 4'd5,  W_MEMWR_DN);

    // Illegal opcode flagged in DECODE, back to FETCH next.
    step("ill_fetch",  0, 1, BAD, 0, 4'd0,  W_FETCH);
    step("ill_dec",    0, 1, BAD, 0, 4'd1,  W_DECILL);
    step("ill_back",   0, 1, RT,  0, 4'd0,  W_FETCH);

    // R-type aborted by reset in RTYPEEX, then a clean R-type.
    step("rta_dec",    0, 1, RT,  0, 4'd1,  W_DEC);
    step("rta_ex_rst", 1, 1, RT,  0, 4'd6,  W_RTEX_RST);
    step("rta_after",  0, 0, RT,  0, 4'd0,  W_FWAIT);
    step("rt_fetch",   0, 1, RT,  0, 4'd0,  W_FETCH);
    step("rt_dec",     0, 1, RT,  0, 4'd1,  W_DEC);
    step("rt_ex",      0, 1, RT,  0, 4'd6,  W_RTEX);
    step("rt_wb",      0, 1, RT,  0, 4'd7,  W_RTWB);

    // addi and j.
    step("addi_fetch", 0, 1, ADDI, 0, 4'd0, W_FETCH);
    step("addi_dec",   0, 1, ADDI, 0, 4'd1, W_DEC);
    step("addi_ex",    0, 1, ADDI, 0, 4'd9, W_ADR);
    step("addi_wb",    0, 1, ADDI, 0, 4'd10, W_ADDIWB);
    step("j_fetch",    0, 1, JMP, 0, 4'd0,  W_FETCH);
    step("j_dec",      0, 1, JMP, 0, 4'd1,  W_DEC);
    step("j_ex",       0, 1, JMP, 0, 4'd11, W_JEX);
    step("end_fetch",  0, 0, RT,  0, 4'd0,  W_FWAIT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
